// File: rtl/channel_op_scheduler_pkg.sv
// Shared opcodes, FSM states and channel-word constants
// for the channel operation scheduler.
package channel_op_scheduler_pkg;

    typedef enum logic [1:0] {
        OP_ENABLE  = 2'd0,
        OP_DISABLE = 2'd1,
        OP_SEND    = 2'd2,
        OP_RSVD    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int CHANNEL_EMPTY = 0;

    function automatic logic op_is_legal(input op_e op);
        return op != OP_RSVD;
    endfunction

endpackage

// File: rtl/channel_op_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational grant, registered pointer
// that moves to winner+1 whenever a grant is taken.
module channel_op_scheduler_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic          any_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;

    // Scan from the highest offset down so the nearest requester wins.
    function automatic logic [IW:0] pick(
        input logic [N-1:0]  r,
        input logic [IW-1:0] p
    );
        logic [IW:0] res;
        int c;
        res = '0;
        for (int i = N - 1; i >= 0; i--) begin
            c = int'(p) + i;
            if (c >= N) c = c - N;
            if (r[c]) res = {1'b1, IW'(c)};
        end
        return res;
    endfunction

    always_comb begin
        {any_o, idx_o} = pick(req_i, ptr_q);
        ptr_d = ptr_q;
        if (advance_i && any_o) begin
            if (int'(idx_o) == N - 1) ptr_d = '0;
            else ptr_d = idx_o + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end

endmodule

// File: rtl/channel_op_scheduler.sv
// Serialises ENABLE/DISABLE/SEND channel operations from several
// requesters onto one single-port RAM as atomic read-modify-writes.
module channel_op_scheduler
    import channel_op_scheduler_pkg::*;
#(
    parameter int addrBits = 16,
    parameter int dataBits = 16,
    parameter int numReq   = 4
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic [numReq-1:0]            reqValid,
    input  logic [2*numReq-1:0]          reqOp,
    input  logic [addrBits*numReq-1:0]   reqChannel,
    input  logic [addrBits*numReq-1:0]   reqPid,
    output logic [numReq-1:0]            ack,
    output logic                         result,
    output logic [addrBits-1:0]          partnerPid,
    output logic                         error,
    output logic [addrBits-1:0]          address,
    output logic                         readWriteMode,
    output logic [dataBits-1:0]          dataIn,
    input  logic [dataBits-1:0]          dataOut
);

    localparam int IW = $clog2(numReq);
    localparam logic [dataBits-1:0] EMPTY = dataBits'(CHANNEL_EMPTY);

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [addrBits-1:0]   chan_q, chan_d;
    logic [addrBits-1:0]   pid_q, pid_d;
    logic [IW-1:0]         win_q, win_d;
    logic                  pres_q, pres_d;
    logic [addrBits-1:0]   ppart_q, ppart_d;
    logic                  res_q, res_d;
    logic [addrBits-1:0]   part_q, part_d;
    logic                  err_q, err_d;
    logic [addrBits-1:0]   addr_q, addr_d;
    logic                  rwm_q, rwm_d;
    logic [dataBits-1:0]   din_q, din_d;
    logic [numReq-1:0]     ack_q, ack_d;

    logic                  g_any;
    logic [IW-1:0]         g_idx;
    logic                  advance;
    op_e                   g_op;
    logic [addrBits-1:0]   g_chan;
    logic [addrBits-1:0]   g_pid;
    logic [dataBits-1:0]   pid_ext;
    logic                  wr;
    logic                  r;
    logic [dataBits-1:0]   wval;

    channel_op_scheduler_rr_arbiter #(
        .N  (numReq),
        .IW (IW)
    ) u_arb (
        .clk       (clk),
        .resetN    (resetN),
        .req_i     (reqValid),
        .advance_i (advance),
        .any_o     (g_any),
        .idx_o     (g_idx)
    );

    assign g_op    = op_e'(reqOp[2*g_idx +: 2]);
    assign g_chan  = reqChannel[addrBits*g_idx +: addrBits];
    assign g_pid   = reqPid[addrBits*g_idx +: addrBits];
    assign pid_ext = dataBits'(pid_q);

    // Channel-word rules; a nonzero word is the waiting party's PID.
    always_comb begin
        wr   = 1'b0;
        r    = 1'b0;
        wval = EMPTY;
        unique case (op_q)
            OP_ENABLE: begin
                if (dataOut == EMPTY) begin
                    wr   = 1'b1;
                    wval = pid_ext;
                end else begin
                    r = 1'b1;
                end
            end
            OP_DISABLE: begin
                if (dataOut == pid_ext) wr = 1'b1;
                else r = (dataOut != EMPTY);
            end
            OP_SEND: begin
                wr = 1'b1;
                if (dataOut == EMPTY) wval = pid_ext;
                else r = 1'b1;
            end
            default: begin
                wr = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        chan_d  = chan_q;
        pid_d   = pid_q;
        win_d   = win_q;
        pres_d  = pres_q;
        ppart_d = ppart_q;
        res_d   = res_q;
        part_d  = part_q;
        err_d   = err_q;
        addr_d  = '0;
        rwm_d   = 1'b0;
        din_d   = '0;
        ack_d   = '0;
        advance = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (g_any) begin
                    advance = 1'b1;
                    op_d    = g_op;
                    chan_d  = g_chan;
                    pid_d   = g_pid;
                    win_d   = g_idx;
                    if (!op_is_legal(g_op) || g_pid == '0) begin
                        state_d      = ST_DONE;
                        res_d        = 1'b0;
                        part_d       = '0;
                        err_d        = 1'b1;
                        ack_d[g_idx] = 1'b1;
                    end else begin
                        addr_d  = g_chan;
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                addr_d  = chan_q;
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                pres_d  = r;
                ppart_d = dataOut[addrBits-1:0];
                if (wr) begin
                    addr_d  = chan_q;
                    din_d   = wval;
                    rwm_d   = 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    state_d      = ST_DONE;
                    res_d        = r;
                    part_d       = dataOut[addrBits-1:0];
                    err_d        = 1'b0;
                    ack_d[win_q] = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d      = ST_DONE;
                res_d        = pres_q;
                part_d       = ppart_q;
                err_d        = 1'b0;
                ack_d[win_q] = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ENABLE;
            chan_q  <= '0;
            pid_q   <= '0;
            win_q   <= '0;
            pres_q  <= 1'b0;
            ppart_q <= '0;
            res_q   <= 1'b0;
            part_q  <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            rwm_q   <= 1'b0;
            din_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            chan_q  <= chan_d;
            pid_q   <= pid_d;
            win_q   <= win_d;
            pres_q  <= pres_d;
            ppart_q <= ppart_d;
            res_q   <= res_d;
            part_q  <= part_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            rwm_q   <= rwm_d;
            din_q   <= din_d;
            ack_q   <= ack_d;
        end
    end

    assign ack           = ack_q;
    assign result        = res_q;
    assign partnerPid    = part_q;
    assign error         = err_q;
    assign address       = addr_q;
    assign readWriteMode = rwm_q;
    assign dataIn        = din_q;

endmodule

// File: tb/tb_channel_op_scheduler.sv
// Scoreboard bench: a channel-word model predicts grant order, ack
// cycle and outcome; a negedge monitor pops and compares on each ack.
module tb_channel_op_scheduler;

    typedef struct {
        int          req;
        logic        res;
        logic [15:0] part;
        logic        err;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetN;
    logic [3:0]  reqValid;
    logic [7:0]  reqOp;
    logic [63:0] reqChannel;
    logic [63:0] reqPid;
    logic [3:0]  ack;
    logic        result;
    logic [15:0] partnerPid;
    logic        error;
    logic [15:0] address;
    logic        readWriteMode;
    logic [15:0] dataIn;
    logic [15:0] dataOut;

    logic [15:0] ram [0:63];
    logic [15:0] mdl [0:63];
    logic        clr;
    logic        pre_en;
    logic [5:0]  pre_addr;
    logic [15:0] pre_data;
    int          wr_cnt;
    logic        oob;
    int          cyc;

    exp_t        sbq [$];
    exp_t        mon_e;
    int          rr;
    logic [1:0]  b_op [4];
    logic [15:0] b_ch [4];
    logic [15:0] b_pid [4];

    int total = 0;
    int bad   = 0;

    channel_op_scheduler dut (
        .clk           (clk),
        .resetN        (resetN),
        .reqValid      (reqValid),
        .reqOp         (reqOp),
        .reqChannel    (reqChannel),
        .reqPid        (reqPid),
        .ack           (ack),
        .result        (result),
        .partnerPid    (partnerPid),
        .error         (error),
        .address       (address),
        .readWriteMode (readWriteMode),
        .dataIn        (dataIn),
        .dataOut       (dataOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM behind the scheduler.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= '0;
            wr_cnt <= 0;
            oob    <= 1'b0;
        end else begin
            if (address >= 16'd64) oob <= 1'b1;
            if (pre_en) begin
                ram[pre_addr] <= pre_data;
            end else if (readWriteMode) begin
                ram[address[5:0]] <= dataIn;
                wr_cnt <= wr_cnt + 1;
            end
            dataOut <= ram[address[5:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetN === 1'b1 && ack !== 4'b0) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack=%b expected none",
                         ack);
            end else begin
                mon_e = sbq.pop_front();
                chk("ack_onehot", 32'(ack), 32'(1) << mon_e.req);
                chk("ack_cycle", cyc, mon_e.at);
                chk("error", 32'(error), 32'(mon_e.err));
                if (!mon_e.err) begin
                    chk("result", 32'(result), 32'(mon_e.res));
                    chk("partnerPid", 32'(partnerPid), 32'(mon_e.part));
                end
            end
        end
    end

    task automatic model_op(input logic [1:0] op, input logic [15:0] ch,
                            input logic [15:0] pid, output exp_t e,
                            output int wr);
        logic [15:0] w;
        int a;
        a = int'(ch[5:0]);
        e.req = 0;
        e.err = 1'b0;
        e.res = 1'b0;
        e.part = '0;
        wr = 0;
        if (op == 2'd3 || pid == 16'd0) begin
            e.err = 1'b1;
            e.at = 1;
            return;
        end
        w = mdl[a];
        e.part = w;
        case (op)
            2'd0: begin
                if (w == 0) begin mdl[a] = pid; wr = 1; end
                else e.res = 1'b1;
            end
            2'd1: begin
                if (w == pid) begin mdl[a] = 0; wr = 1; end
                else e.res = (w != 0);
            end
            default: begin
                wr = 1;
                if (w == 0) mdl[a] = pid;
                else begin mdl[a] = 0; e.res = 1'b1; end
            end
        endcase
        e.at = wr ? 4 : 3;
    endtask

    task automatic preset(input int a, input logic [15:0] v);
        @(negedge clk);
        pre_addr = 6'(a);
        pre_data = v;
        pre_en   = 1'b1;
        mdl[a]   = v;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic setreq(input int i, input int op, input int ch,
                          input int pid);
        b_op[i]  = 2'(op);
        b_ch[i]  = 16'(ch);
        b_pid[i] = 16'(pid);
    endtask

    task automatic run_batch(input logic [3:0] mask);
        logic [3:0] left;
        int t, k, wr, expw, w0, mism;
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                reqOp[2*i +: 2]       = b_op[i];
                reqChannel[16*i +: 16] = b_ch[i];
                reqPid[16*i +: 16]     = b_pid[i];
            end
        end
        reqValid = mask;
        t = cyc;
        w0 = wr_cnt;
        expw = 0;
        left = mask;
        while (left != 0) begin
            k = -1;
            for (int off = 0; off < 4; off++) begin
                if (k < 0 && left[(rr + off) % 4]) k = (rr + off) % 4;
            end
            left[k] = 1'b0;
            rr = (k + 1) % 4;
            model_op(b_op[k], b_ch[k], b_pid[k], e, wr);
            e.req = k;
            e.at = t + e.at;
            t = e.at + 1;
            expw += wr;
            sbq.push_back(e);
        end
        for (int c = 0; c < 80 && reqValid != 4'b0; c++) begin
            @(negedge clk);
            reqValid = reqValid & ~ack;
        end
        if (reqValid != 4'b0) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got pending=%b expected 0000",
                     reqValid);
            reqValid = '0;
            sbq.delete();
        end
        @(negedge clk);
        mism = 0;
        for (int i = 0; i < 64; i++) if (ram[i] !== mdl[i]) mism++;
        chk("ram_writes", wr_cnt - w0, expw);
        chk("ram_image_mismatches", mism, 0);
        chk("addr_in_range", 32'(oob), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetN = 1'b0;
        clr = 1'b1;
        pre_en = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        reqValid = '0;
        reqOp = '0;
        reqChannel = '0;
        reqPid = '0;
        cyc = 0;
        rr = 0;
        for (int i = 0; i < 64; i++) mdl[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_partner", 32'(partnerPid), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_address", 32'(address), 0);
        chk("rst_rwm", 32'(readWriteMode), 0);
        chk("rst_dataIn", 32'(dataIn), 0);
        clr = 1'b0;
        resetN = 1'b1;
        @(negedge clk);

        // contention on distinct channels, then a partial re-raise
        for (int i = 0; i < 4; i++) setreq(i, 0, 10 + i, i + 1);
        run_batch(4'b1111);
        setreq(0, 2, 10, 9);
        setreq(3, 1, 13, 4);
        run_batch(4'b1001);

        // ENABLE with and without a waiting sender
        preset(2, 16'd0);
        setreq(0, 0, 2, 1);
        run_batch(4'b0001);
        preset(2, 16'd3);
        setreq(0, 0, 2, 1);
        run_batch(4'b0001);

        // SEND rendezvous, then SEND on the now-empty channel
        preset(5, 16'd7);
        setreq(1, 2, 5, 4);
        run_batch(4'b0010);
        run_batch(4'b0010);

        // two requesters on one channel
        preset(8, 16'd0);
        setreq(0, 2, 8, 2);
        setreq(1, 0, 8, 6);
        run_batch(4'b0011);

        // reserved opcode and zero PID
        setreq(2, 3, 9, 5);
        run_batch(4'b0100);
        setreq(3, 0, 9, 0);
        run_batch(4'b1000);

        // reset while the write is on the RAM port
        preset(20, 16'd0);
        @(negedge clk);
        reqOp[5:4] = 2'd0;
        reqChannel[47:32] = 16'd20;
        reqPid[47:32] = 16'd5;
        reqValid = 4'b0100;
        begin
            int c;
            for (c = 0; c < 10 && readWriteMode !== 1'b1; c++)
                @(negedge clk);
            chk("write_seen_before_reset", 32'(readWriteMode), 1);
        end
        resetN = 1'b0;
        #1;
        chk("abort_ack", 32'(ack), 0);
        chk("abort_result", 32'(result), 0);
        chk("abort_rwm", 32'(readWriteMode), 0);
        chk("abort_address", 32'(address), 0);
        reqValid = '0;
        @(negedge clk);
        resetN = 1'b1;
        rr = 0;
        preset(20, 16'd0);
        setreq(0, 0, 21, 3);
        setreq(1, 0, 22, 6);
        run_batch(4'b0011);

        // randomized traffic on a few shared channels
        for (int n = 0; n < 80; n++) begin
            logic [3:0] m;
            int sel;
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                sel = $urandom_range(0, 9);
                setreq(i, sel < 3 ? 0 : sel < 6 ? 1 : sel < 9 ? 2 : 3,
                       $urandom_range(0, 7), $urandom_range(0, 7));
            end
            run_batch(m);
        end

        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/channel_op_scheduler.md
Name: channel_op_scheduler

Overview:
- Shares the single-port IceRam between `numReq` channel-operation requesters (cores/process engines).
- Performs each channel operation (ENABLE, DISABLE, SEND) as an atomic read-modify-write of the channel word.
- Sits between the per-core channel logic and the memory. Operations on the same channel from different requesters are serialised, so no rendezvous races.
- Channel word encoding: 0 = empty; nonzero = PID of the waiting party.

Parameters:
- addrBits, 16, memory address width; also the PID width.
- dataBits, 16, memory word width; must be >= addrBits.
- numReq, 4, number of requesters; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- reqValid  in  numReq  per-requester request; held high until that requester's ack.
- reqOp  in  2*numReq  per-requester opcode: 0 ENABLE, 1 DISABLE, 2 SEND, 3 reserved.
- reqChannel  in  addrBits*numReq  per-requester channel word address.
- reqPid  in  addrBits*numReq  per-requester PID of the caller.
- ack  out  numReq  one-hot, one-cycle completion pulse.
- result  out  1  op outcome; valid while any ack bit is high.
- partnerPid  out  addrBits  PID read from the channel word; valid with ack.
- error  out  1  reserved opcode or reqPid==0; valid with ack.
- address  out  addrBits  RAM address.
- readWriteMode  out  1  RAM mode: 1 = write, 0 = read.
- dataIn  out  dataBits  RAM write data, zero-extended.
- dataOut  in  dataBits  RAM read data; synchronous, valid one cycle after the address is presented.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0.
- Reset assertion mid-operation aborts the operation; no ack is issued.
- readWriteMode drops to 0 asynchronously on reset. A write in flight at reset is not guaranteed.
- States and transitions:
  - IDLE: if any reqValid, pick the winner by round-robin, starting at the index after the last grant.
    - Latch the winner's op/channel/pid.
    - If error: go to DONE.
    - Else: drive address=channel, readWriteMode=0, go to READ.
  - READ: hold the address; go to EVAL.
  - EVAL: sample dataOut as w; set partnerPid = w[addrBits-1:0]; apply the op rules below.
  - WRITE: deassert readWriteMode; go to DONE.
  - DONE: pulse ack[winner] for one cycle with result/partnerPid/error; go to IDLE.
- Op rules in EVAL:
  - ENABLE: if w==0, write pid, result=0. Else result=1 (sender present), no write.
  - DISABLE: if w==pid, write 0, result=0. Else if w==0, result=0, no write. Else result=1, no write.
  - SEND: if w==0, write pid, result=0 (sender blocks). Else write 0, result=1 (receiver w ready).
- Writes are issued in EVAL: drive address=channel, dataIn=value, readWriteMode=1, then go to WRITE.
- If no write is needed, EVAL goes straight to DONE.
- Latency (request sampled in IDLE at cycle 0):
  - ack at cycle 3 with no write;
  - ack at cycle 4 with a write;
  - ack at cycle 1 on error, with no memory access.
- Requester rules:
  - A requester drops reqValid at the edge where it sees ack, or keeps it high to present a new operation.
  - Fields must be stable while reqValid is high. The scheduler samples them only in IDLE.
- Simultaneous requests are fair: no requester waits more than numReq-1 grants. Pointer advances to winner+1 modulo numReq.
- Back-to-back operations: IDLE follows DONE, so minimum spacing is one idle cycle between operations.
- Atomicity: exactly one operation is in flight. Two requesters on the same channel see sequential results.
- Outside ack cycles, result/partnerPid/error hold their last values.
- address/dataIn are don't-care when not in READ/EVAL/WRITE; drive them to 0.

Decomposition:
- Shared package/header (defaults.vh):
  - opcode constants: OP_ENABLE=0, OP_DISABLE=1, OP_SEND=2;
  - state encodings;
  - CHANNEL_EMPTY=0.
- One natural sub-module: rr_arbiter (numReq-wide round-robin, combinational grant plus registered pointer).

Test Plan:
- ENABLE, no sender: ram[2]=0; req0 op ENABLE, channel 2, pid 1 -> ack[0] at cycle 4, result=0, ram[2]==1.
- ENABLE, sender present: ram[2]=3; req0 ENABLE, pid 1 -> ack[0] at cycle 3, result=1, partnerPid=3, ram[2] stays 3, no write cycle.
- SEND rendezvous: ram[5]=7 (receiver waiting); req1 SEND, channel 5, pid 4 -> result=1, partnerPid=7, ram[5]==0. Repeat on the empty channel -> result=0, ram[5]==4.
- Contention: req0..3 all raised at once, each with ENABLE on distinct channels 10..13 -> acks in order 0,1,2,3. Re-raise req0 and req3 -> grant order 0 then 3.
- Same channel: req0 SEND pid 2 and req1 ENABLE pid 6, both on channel 8, ram[8]=0 -> req0 first: result 0, ram[8]=2. Then req1: result 1, partnerPid 2.
- Errors and reset: op 3 -> ack at cycle 1, error=1, no RAM access. Assert resetN=0 during WRITE -> ack, result, readWriteMode all 0 immediately; after release, state IDLE.
